instr_stream_encoder: RTL
=========================

Name: instr_stream_encoder

Overview:
Sequential instruction encoder and loader, the inverse of the control decoder. It accepts symbolic instruction records (mnemonic plus fields) over a valid/ready handshake and packs each into a 32-bit MIPS word. It writes the words one at a time into instruction memory at consecutive word addresses. On request it appends a terminating self-jump. Used by bring-up benches and the boot path to build programs for the toy CPU.

Parameters:
ADDR_W, 8, width of instruction-memory word address.
DEPTH, 256, number of writable words (must be <= 2**ADDR_W).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
op_valid  in  1  instruction record present
op_ready  out  1  encoder can accept a record
op_kind  in  5  mnemonic: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 MUL,8 DIV,9 SLL,10 SRL,11 SRA,12 LW,13 SW,14 BEQ,15 BNE,16 J; 17-31 illegal
rs, rt, rd  in  5 each  register fields
shamt  in  5  shift amount (SLL/SRL/SRA only)
imm16  in  16  immediate/offset (LW/SW/BEQ/BNE)
target26  in  26  jump target (J)
finish  in  1  pulse: append halt and stop
clear  in  1  pulse: return to empty, clear done/flags
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  encoded word
count  out  ADDR_W+1  words written so far
done  out  1  program closed
err_illegal  out  1  one-cycle pulse, illegal op_kind rejected
err_full  out  1  sticky: finish arrived with no room for halt

Behaviour:
- Reset: state IDLE, op_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err_illegal=0, err_full=0. Reset mid-write aborts with no further strobe. The pointer returns to 0.
- States: IDLE, ENCODE, WRITE, DONE.
- IDLE: op_ready = (count<DEPTH) && !done. Handshake fires when op_valid&&op_ready.
  - On the handshake: latch all fields, then go to ENCODE.
  - finish takes priority over op_valid in the same cycle. In that case no record is accepted.
- ENCODE (1 cycle): register the word.
  - R-type: opcode 000000, rs, rt, rd, shamt=0, funct ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, MUL 011000, DIV 011010.
  - Shifts: rs=0, rt, rd, shamt, funct SLL 000000, SRL 000010, SRA 000011.
  - I-type: LW 100011, SW 101011, BEQ 000100, BNE 000101. Layout is {op,rs,rt,imm16}.
  - J: {000010,target26}.
  - Legal op_kind: go to WRITE.
  - Illegal op_kind: pulse err_illegal, leave count unchanged, return to IDLE.
- WRITE (1 cycle): imem_we=1, imem_addr=count[ADDR_W-1:0], imem_wdata=registered word. count increments at the end of the cycle.
  - Next state is IDLE, or DONE if the write is the halt.
- Latency and throughput:
  - Handshake in cycle T gives imem_we in cycle T+2.
  - op_ready is low in ENCODE and WRITE.
  - Maximum rate is one record per 3 cycles.
- finish in IDLE, count<DEPTH: build halt {000010, zero-extended count} in ENCODE, then go to WRITE, then DONE.
- finish in IDLE, count==DEPTH: set err_full, go straight to DONE, no write.
- finish outside IDLE is ignored. Callers must wait for op_ready or done.
- DONE: done=1, op_ready=0, and op_valid is ignored. Only clear or rst exits.
- clear is honoured in IDLE and DONE: count=0, done=0, err_full=0, state IDLE. clear is ignored in ENCODE and WRITE.
- Full: count==DEPTH drops op_ready. No wrap-around and no overwrite.
- Field inputs are sampled only on the handshake cycle. Later changes have no effect.

Decomposition:
- Shared package mips_isa_pkg holds the opcode and funct localparams (shared with the decoder), the op_kind encoding constants, and the J/halt opcode.
- Sub-module instr_word_encoder: combinational packer taking op_kind and fields, producing word[31:0] and legal. The FSM, pointer and handshake stay in the top.

Test Plan:
- ADD rs=1 rt=2 rd=3 accepted at T -> imem_we at T+2, addr 0, wdata 0x00221820; count=1.
- LW rs=4 rt=5 imm16=0x0008, then SLL rt=1 rd=2 shamt=4 -> addr1 0x8C850008, addr2 0x00011100.
- BEQ rs=1 rt=2 imm16=0xFFFF at count 3, then finish -> addr3 0x1022FFFF, addr4 0x08000004, done=1, op_ready=0.
- op_kind=20 -> err_illegal single pulse, no imem_we, count unchanged, op_ready back high 2 cycles after the handshake.
- DEPTH=4: four legal records, then op_ready=0; finish -> err_full=1, done=1, no write; clear -> count=0, flags low.
- rst asserted during WRITE -> imem_we drops immediately, count=0. op_valid with finish in the same IDLE cycle -> halt only.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS encoding constants: opcodes, R-type functs, op_kind mnemonics,
// plus the packed instruction-record type the encoder latches on a handshake.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] KIND_ADD = 5'd0;
  localparam logic [4:0] KIND_SUB = 5'd1;
  localparam logic [4:0] KIND_AND = 5'd2;
  localparam logic [4:0] KIND_OR  = 5'd3;
  localparam logic [4:0] KIND_XOR = 5'd4;
  localparam logic [4:0] KIND_NOR = 5'd5;
  localparam logic [4:0] KIND_SLT = 5'd6;
  localparam logic [4:0] KIND_MUL = 5'd7;
  localparam logic [4:0] KIND_DIV = 5'd8;
  localparam logic [4:0] KIND_SLL = 5'd9;
  localparam logic [4:0] KIND_SRL = 5'd10;
  localparam logic [4:0] KIND_SRA = 5'd11;
  localparam logic [4:0] KIND_LW  = 5'd12;
  localparam logic [4:0] KIND_SW  = 5'd13;
  localparam logic [4:0] KIND_BEQ = 5'd14;
  localparam logic [4:0] KIND_BNE = 5'd15;
  localparam logic [4:0] KIND_J   = 5'd16;

  typedef struct packed {
    logic [4:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] target26;
  } instr_rec_t;

  // The halt is a jump to its own word address.
  function automatic logic [31:0] halt_word(input logic [25:0] self_addr);
    return {OP_J, self_addr};
  endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational packer: one symbolic instruction record in, one 32-bit MIPS
// word out, with legal low for op_kind values outside the supported set.
module instr_word_encoder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op_kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_kind)
      KIND_ADD: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      KIND_SUB: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      KIND_AND: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      KIND_OR:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      KIND_XOR: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_XOR};
      KIND_NOR: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
      KIND_SLT: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      KIND_MUL: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_MUL};
      KIND_DIV: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_DIV};
      // Shifts take their operand from rt; the rs slot is forced to zero.
      KIND_SLL: word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      KIND_SRL: word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      KIND_SRA: word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRA};
      KIND_LW:  word = {OP_LW,  rs, rt, imm16};
      KIND_SW:  word = {OP_SW,  rs, rt, imm16};
      KIND_BEQ: word = {OP_BEQ, rs, rt, imm16};
      KIND_BNE: word = {OP_BNE, rs, rt, imm16};
      KIND_J:   word = {OP_J, target26};
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts instruction records over valid/ready, encodes each and writes it to
// instruction memory at consecutive addresses; finish appends a self-jump halt.
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [4:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  input  logic              finish,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENCODE = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]      state_reg;
  logic [ADDR_W:0] count_reg;
  instr_rec_t      rec_reg;
  logic            halt_pending_reg;
  logic [31:0]     word_reg;
  logic            err_illegal_reg;
  logic            err_full_reg;

  logic [31:0]     enc_word;
  logic            enc_legal;
  logic            room;

  assign room = (count_reg < DEPTH_C);

  instr_word_encoder u_word_encoder (
    .op_kind  (rec_reg.kind),
    .rs       (rec_reg.rs),
    .rt       (rec_reg.rt),
    .rd       (rec_reg.rd),
    .shamt    (rec_reg.shamt),
    .imm16    (rec_reg.imm16),
    .target26 (rec_reg.target26),
    .word     (enc_word),
    .legal    (enc_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      count_reg        <= '0;
      rec_reg          <= '0;
      halt_pending_reg <= 1'b0;
      word_reg         <= '0;
      err_illegal_reg  <= 1'b0;
      err_full_reg     <= 1'b0;
    end else begin
      err_illegal_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // clear beats finish, and finish beats a pending record.
          if (clear) begin
            count_reg    <= '0;
            err_full_reg <= 1'b0;
          end else if (finish) begin
            if (room) begin
              halt_pending_reg <= 1'b1;
              state_reg        <= S_ENCODE;
            end else begin
              err_full_reg <= 1'b1;
              state_reg    <= S_DONE;
            end
          end else if (op_valid && room) begin
            rec_reg   <= '{kind: op_kind, rs: rs, rt: rt, rd: rd, shamt: shamt,
                           imm16: imm16, target26: target26};
            state_reg <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (halt_pending_reg) begin
            word_reg  <= halt_word(26'(count_reg));
            state_reg <= S_WRITE;
          end else if (enc_legal) begin
            word_reg  <= enc_word;
            state_reg <= S_WRITE;
          end else begin
            err_illegal_reg <= 1'b1;
            state_reg       <= S_IDLE;
          end
        end
        S_WRITE: begin
          count_reg        <= count_reg + 1'b1;
          halt_pending_reg <= 1'b0;
          state_reg        <= halt_pending_reg ? S_DONE : S_IDLE;
        end
        default: begin
          if (clear) begin
            count_reg    <= '0;
            err_full_reg <= 1'b0;
            state_reg    <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Write strobe is decoded from state so an asynchronous reset kills it at once.
  assign op_ready    = (state_reg == S_IDLE) && room;
  assign imem_we     = (state_reg == S_WRITE);
  assign imem_addr   = count_reg[ADDR_W-1:0];
  assign imem_wdata  = word_reg;
  assign count       = count_reg;
  assign done        = (state_reg == S_DONE);
  assign err_illegal = err_illegal_reg;
  assign err_full    = err_full_reg;

endmodule
